// File: rtl/multdiv_ctrl_pkg.sv
// Shared definitions for the mult/div sequencer: state encoding and default
// step counts.
package multdiv_ctrl_pkg;

  localparam int CNT_W_DEF      = 5;
  localparam int MULT_STEPS_DEF = 32;
  localparam int DIV_STEPS_DEF  = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/multdiv_ctrl_step_counter.sv
// Iteration counter for the mult/div RUN phase. Clears synchronously, counts
// while enabled and flags when it sits on the last step index.
module multdiv_step_counter #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] last,
  output logic [CNT_W-1:0] count,
  output logic             term
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  // Count register: clear wins over enable.
  always_ff @(posedge clk) begin
    if (reset || clr) count <= '0;
    else if (en)      count <= count + ONE;
  end

  assign term = (count == last);

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencer for the iterative multiply/divide datapath.
// Handshake: ctrl_MULT/ctrl_DIV are single-cycle start pulses with no ready
// back-pressure; a start is accepted in any state and restarts the sequence.
// data_resultRDY is a single-cycle done pulse and data_exception is only
// meaningful while it is high.
module multdiv_ctrl
  import multdiv_ctrl_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int MULT_STEPS = MULT_STEPS_DEF,
  parameter int DIV_STEPS  = DIV_STEPS_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic             dp_divisor_zero,
  input  logic             dp_overflow,
  output logic             load_operands,
  output logic             op_is_div,
  output logic             step_en,
  output logic [CNT_W-1:0] step_count,
  output logic             busy,
  output logic             data_resultRDY,
  output logic             data_exception,
  output state_t           dbg_state
);

  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_STEPS - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_STEPS - 1);

  state_t           state, state_nx;
  logic             start, start_div;
  logic             op_q, dz_q;
  logic [CNT_W-1:0] cnt, last;
  logic             term, cnt_clr, cnt_en;

  // Multiply has priority when both starts arrive together.
  assign start     = ctrl_MULT | ctrl_DIV;
  assign start_div = ctrl_DIV & ~ctrl_MULT;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Operation and divide-by-zero latches, captured on every accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q <= 1'b0;
      dz_q <= 1'b0;
    end else if (start) begin
      op_q <= start_div;
      dz_q <= start_div & dp_divisor_zero;
    end
  end

  // Next-state logic: a start always restarts into LOAD, aborting any op.
  always_comb begin
    state_nx = state;
    if (start) begin
      state_nx = ST_LOAD;
    end else begin
      case (state)
        ST_IDLE:   state_nx = ST_IDLE;
        ST_LOAD:   state_nx = dz_q ? ST_FINISH : ST_RUN;
        ST_RUN:    state_nx = term ? ST_FINISH : ST_RUN;
        ST_FINISH: state_nx = ST_IDLE;
        default:   state_nx = ST_IDLE;
      endcase
    end
  end

  // The counter holds on its last index instead of wrapping back to zero.
  assign cnt_clr = (state == ST_LOAD);
  assign cnt_en  = (state == ST_RUN) && !term;
  assign last    = op_q ? DIV_LAST : MULT_LAST;

  multdiv_step_counter #(.CNT_W(CNT_W)) u_step_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .last  (last),
    .count (cnt),
    .term  (term)
  );

  // Output decode from the state register; exception is live only in FINISH.
  always_comb begin
    load_operands  = 1'b0;
    step_en        = 1'b0;
    step_count     = '0;
    busy           = 1'b0;
    data_resultRDY = 1'b0;
    data_exception = 1'b0;
    case (state)
      ST_LOAD: begin
        load_operands = 1'b1;
        busy          = 1'b1;
      end
      ST_RUN: begin
        step_en    = 1'b1;
        step_count = cnt;
        busy       = 1'b1;
      end
      ST_FINISH: begin
        busy           = 1'b1;
        data_resultRDY = 1'b1;
        data_exception = op_q ? dz_q : dp_overflow;
      end
      default: ;
    endcase
  end

  assign op_is_div = op_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl: a table of single operations checked cycle
// by cycle against the documented timeline, plus hand-written sequences for
// abort, reset and back-to-back corner cases.
module tb_multdiv_ctrl;
  import multdiv_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       ctrl_MULT, ctrl_DIV, dp_divisor_zero, dp_overflow;
  logic       load_operands, op_is_div, step_en, busy;
  logic       data_resultRDY, data_exception;
  logic [4:0] step_count;
  state_t     dbg_state;

  int passed = 0;
  int total  = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic mult;
    logic div;
    logic dz;
    logic ovf;      // dp_overflow driven in the FINISH cycle
    int   lat;      // start -> resultRDY
    logic exp_exc;
    logic exp_op;
  } vec_t;

  vec_t vecs[6];

  multdiv_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .ctrl_MULT       (ctrl_MULT),
    .ctrl_DIV        (ctrl_DIV),
    .dp_divisor_zero (dp_divisor_zero),
    .dp_overflow     (dp_overflow),
    .load_operands   (load_operands),
    .op_is_div       (op_is_div),
    .step_en         (step_en),
    .step_count      (step_count),
    .busy            (busy),
    .data_resultRDY  (data_resultRDY),
    .data_exception  (data_exception),
    .dbg_state       (dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] pk(logic ld, logic op, logic en,
                                     logic [4:0] cnt, logic bsy,
                                     logic rdy, logic exc);
    return {ld, op, en, cnt, bsy, rdy, exc};
  endfunction

  function automatic logic [10:0] outs();
    return pk(load_operands, op_is_div, step_en, step_count, busy,
              data_resultRDY, data_exception);
  endfunction

  task automatic check(input string name, input logic [10:0] act,
                       input logic [10:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard hook: every resultRDY must match the next expected cycle.
  task automatic watch_rdy(input string name, input int k);
    if (data_resultRDY === 1'b1) begin
      if (exp_q.size() == 0) check({name, " spurious rdy"}, 11'(k), 11'h7ff);
      else                   check({name, " rdy cycle"}, 11'(k), 11'(exp_q.pop_front()));
    end
  endtask

  task automatic end_seq(input string name);
    check({name, " missing rdy"}, 11'(exp_q.size()), 11'd0);
    exp_q.delete();
  endtask

  // One operation from the table, checked every cycle until back in IDLE.
  task automatic run_vec(input int idx, input vec_t v);
    logic       run;
    logic [4:0] cnt;
    logic       rdy;
    tick();
    ctrl_MULT = v.mult; ctrl_DIV = v.div; dp_divisor_zero = v.dz; dp_overflow = 1'b1;
    for (int k = 1; k <= v.lat + 1; k++) begin
      tick();
      ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
      dp_divisor_zero = ~v.dz;
      dp_overflow = (k == v.lat) ? v.ovf : 1'b1;
      @(negedge clk);
      run = (k >= 2) && (k <= v.lat - 1);
      cnt = run ? 5'(k - 2) : 5'd0;
      rdy = (k == v.lat);
      check($sformatf("vec%0d cyc%0d", idx, k), outs(),
            pk(k == 1, v.exp_op, run, cnt, k <= v.lat, rdy, rdy & v.exp_exc));
    end
  endtask

  initial begin
    //          mult  div   dz    ovf   lat exc   op
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 34, 1'b0, 1'b0}; // plain multiply
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 34, 1'b1, 1'b0}; // multiply overflow
    vecs[2] = '{0,    1'b1, 1'b0, 1'b1, 34, 1'b0, 1'b1}; // divide ignores overflow
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 2,  1'b1, 1'b1}; // divide by zero
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 34, 1'b0, 1'b0}; // both starts: multiply wins
    vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 2,  1'b1, 1'b1}; // div-zero, overflow irrelevant

    reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    dp_divisor_zero = 1'b0; dp_overflow = 1'b1;
    tick(); tick();
    @(negedge clk);
    check("reset outputs", outs(), 11'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("idle after reset", outs(), 11'd0);

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Divide aborted by a multiply at T+10: only the multiply's RDY, 34 later.
    tick();
    ctrl_DIV = 1'b1; dp_divisor_zero = 1'b0; dp_overflow = 1'b0;
    exp_q.push_back(8'd44);
    for (int k = 1; k <= 48; k++) begin
      tick();
      ctrl_DIV = 1'b0;
      ctrl_MULT = (k == 10);
      @(negedge clk);
      watch_rdy("abort", k);
      if (k == 10) check("abort op_is_div@10", 11'(op_is_div), 11'd1);
      if (k == 11) check("abort op_is_div@11", 11'(op_is_div), 11'd0);
      if (k == 11) check("abort load@11", 11'(load_operands), 11'd1);
    end
    end_seq("abort");

    // Reset at T+20 of a divide: everything zero at T+21, no RDY ever.
    tick();
    ctrl_DIV = 1'b1; dp_divisor_zero = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      ctrl_DIV = 1'b0;
      reset = (k == 20);
      @(negedge clk);
      watch_rdy("reset", k);
      if (k == 20) check("reset step@20", 11'(step_count), 11'd18);
      if (k == 21) check("reset outputs@21", outs(), 11'd0);
    end
    end_seq("reset");

    // Start in the FINISH cycle: that RDY still fires, new op follows.
    tick();
    ctrl_MULT = 1'b1; dp_overflow = 1'b0;
    exp_q.push_back(8'd34);
    exp_q.push_back(8'd68);
    for (int k = 1; k <= 70; k++) begin
      tick();
      ctrl_MULT = (k == 34);
      @(negedge clk);
      watch_rdy("b2b", k);
      if (k == 35) check("b2b load@35", 11'(load_operands), 11'd1);
      if (k == 36) check("b2b step@36", 11'({step_en, step_count}), 11'({1'b1, 5'd0}));
    end
    end_seq("b2b");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
